// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-RAM arbitration bundle: icache/dcache request/response plus the single RAM port.
// The master modport is the arbiter's view; slave is the caches/RAM environment.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-outstanding arbiter of icache/dcache misses onto one RAM port.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module cache_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFETCH = 2'd1;
    localparam logic [1:0] DLOAD  = 2'd2;
    localparam logic [1:0] DSTORE = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] iload_q, dload_q;
    logic [SW-1:0]     starve_cnt;

    logic owner_req, done, starved;

    // owner_req low in an active state means the owner abandoned the request
    always_comb begin
        owner_req = 1'b0;
        case (state)
            IFETCH:        owner_req = bus.iREN;
            DLOAD, DSTORE: owner_req = bus.dREN | bus.dWEN;
            default:       owner_req = 1'b0;
        endcase
    end

    assign done    = owner_req && (bus.ramstate == RAM_ACCESS);
    assign starved = (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (bus.iREN && starved) state_n = IFETCH;
            else if (bus.dWEN)       state_n = DSTORE;
            else if (bus.dREN)       state_n = DLOAD;
            else if (bus.iREN)       state_n = IFETCH;
        end else if (!owner_req || done) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE) begin
                addr_q <= (state_n == IFETCH) ? bus.iaddr : bus.daddr;
                if (state_n == DSTORE) store_q <= bus.dstore;
            end
            if (done && state == IFETCH) iload_q <= bus.ramload;
            if (done && state == DLOAD)  dload_q <= bus.ramload;
            if (done && state == IFETCH)
                starve_cnt <= '0;
            else if (bus.iREN && state != IFETCH && !starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // ERROR/BUSY/FREE all simply keep the enables up, so ERROR becomes a retry
    assign bus.ramREN   = owner_req && (state == IFETCH || state == DLOAD);
    assign bus.ramWEN   = owner_req && (state == DSTORE);
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;

    assign bus.iwait = !(done && state == IFETCH);
    assign bus.dwait = !(done && (state == DLOAD || state == DSTORE));
    assign bus.iload = (done && state == IFETCH) ? bus.ramload : iload_q;
    assign bus.dload = (done && state == DLOAD)  ? bus.ramload : dload_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_cache_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
    localparam int K_I = 0, K_DL = 1, K_DS = 2;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;

    // model: one open transaction (kind, address, data) plus the starvation count
    bit          m_busy;
    int          m_kind;
    logic [31:0] m_addr, m_data, m_iload, m_dload;
    int          m_starve;

    task automatic model_reset();
        m_busy = 0; m_kind = K_I; m_addr = '0; m_data = '0;
        m_iload = '0; m_dload = '0; m_starve = 0;
    endtask

    function automatic bit owner_live();
        if (!m_busy) return 0;
        if (m_kind == K_I) return bus.iREN;
        return bus.dREN | bus.dWEN;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit live, acc;
        live = owner_live();
        acc  = live && bus.ramstate == ACCESS;
        chk("ramREN",   {31'b0, bus.ramREN}, {31'b0, live && m_kind != K_DS});
        chk("ramWEN",   {31'b0, bus.ramWEN}, {31'b0, live && m_kind == K_DS});
        chk("ramaddr",  bus.ramaddr, m_addr);
        chk("ramstore", bus.ramstore, m_data);
        chk("iwait",    {31'b0, bus.iwait}, {31'b0, !(acc && m_kind == K_I)});
        chk("dwait",    {31'b0, bus.dwait}, {31'b0, !(acc && m_kind != K_I)});
        chk("iload",    bus.iload, (acc && m_kind == K_I)  ? bus.ramload : m_iload);
        chk("dload",    bus.dload, (acc && m_kind == K_DL) ? bus.ramload : m_dload);
    endtask

    task automatic model_clock();
        bit live, acc, old_ifetch, starved;
        live       = owner_live();
        acc        = live && bus.ramstate == ACCESS;
        old_ifetch = m_busy && m_kind == K_I;
        starved    = (m_starve == LIM);
        if (acc && m_kind == K_I)  m_iload = bus.ramload;
        if (acc && m_kind == K_DL) m_dload = bus.ramload;
        if (m_busy) begin
            if (!live || acc) m_busy = 0;
        end else if (bus.iREN && starved) begin
            m_busy = 1; m_kind = K_I;  m_addr = bus.iaddr;
        end else if (bus.dWEN) begin
            m_busy = 1; m_kind = K_DS; m_addr = bus.daddr; m_data = bus.dstore;
        end else if (bus.dREN) begin
            m_busy = 1; m_kind = K_DL; m_addr = bus.daddr;
        end else if (bus.iREN) begin
            m_busy = 1; m_kind = K_I;  m_addr = bus.iaddr;
        end
        if (acc && old_ifetch) m_starve = 0;
        else if (bus.iREN && !old_ifetch && m_starve < LIM) m_starve++;
    endtask

    task automatic apply(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        @(negedge clk);
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                        input logic [31:0] rl);
        apply(ir, ia, dr, dw, da, ds, rs, rl);
        tick();
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
    endtask

    initial begin
        bit saw_ifetch;
        logic ir, dr, dw;
        model_reset();
        idle_inputs();
        #2;
        check_all();
        chk("rst_iwait", {31'b0, bus.iwait}, 32'd1);
        @(negedge clk);
        nrst = 1;

        // single fetch completing on the first active cycle
        apply(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF); tick();
        apply(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'hDEADBEEF);
        chk("t2_addr",  bus.ramaddr, 32'h40);
        chk("t2_iload", bus.iload, 32'hDEADBEEF);
        chk("t2_iwait", {31'b0, bus.iwait}, 32'd0);
        tick();
        step(0, 0, 0, 0, 0, 0, FREE, 0);

        // store beats fetch, then fetch follows
        step(1, 32'h44, 0, 1, 32'h80, 32'h1234, BUSY, 0);
        apply(1, 32'h44, 0, 1, 32'h80, 32'h1234, ACCESS, 0);
        chk("t3_wen",   {31'b0, bus.ramWEN}, 32'd1);
        chk("t3_addr",  bus.ramaddr, 32'h80);
        chk("t3_store", bus.ramstore, 32'h1234);
        chk("t3_dwait", {31'b0, bus.dwait}, 32'd0);
        tick();
        step(1, 32'h44, 0, 0, 0, 0, BUSY, 0);
        apply(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'hCAFE);
        chk("t3_iwait", {31'b0, bus.iwait}, 32'd0);
        chk("t3_iaddr", bus.ramaddr, 32'h44);
        tick();

        // starvation: data keeps asking, fetch must still get in
        saw_ifetch = 0;
        for (int k = 0; k < 24; k++) begin
            apply(1, 32'h100, 1, 0, 32'h200, 0, (k % 3 == 2) ? ACCESS : BUSY, 32'h1000 + k);
            if (bus.ramREN && bus.ramaddr == 32'h100) saw_ifetch = 1;
            tick();
        end
        chk("t4_starve_grant", {31'b0, saw_ifetch}, 32'd1);
        step(0, 0, 0, 0, 0, 0, FREE, 0);

        // load retried through ERROR
        step(0, 0, 1, 0, 32'h300, 0, FREE, 0);
        apply(0, 0, 1, 0, 32'h300, 0, ERROR, 32'h5);
        chk("t5_err_ren", {31'b0, bus.ramREN}, 32'd1);
        chk("t5_err_dwait", {31'b0, bus.dwait}, 32'd1);
        tick();
        step(0, 0, 1, 0, 32'h300, 0, ERROR, 32'h6);
        apply(0, 0, 1, 0, 32'h300, 0, ACCESS, 32'h77);
        chk("t5_addr",  bus.ramaddr, 32'h300);
        chk("t5_dwait", {31'b0, bus.dwait}, 32'd0);
        chk("t5_dload", bus.dload, 32'h77);
        tick();
        step(0, 0, 0, 0, 0, 0, FREE, 0);

        // fetch abandoned mid-flight
        step(1, 32'h400, 0, 0, 0, 0, BUSY, 0);
        step(1, 32'h400, 0, 0, 0, 0, BUSY, 0);
        apply(0, 32'h400, 0, 0, 0, 0, BUSY, 0);
        chk("t6_ren",   {31'b0, bus.ramREN}, 32'd0);
        chk("t6_iwait", {31'b0, bus.iwait}, 32'd1);
        tick();
        step(0, 0, 0, 0, 0, 0, ACCESS, 0);

        // asynchronous reset in the middle of a fetch
        step(1, 32'h500, 0, 0, 0, 0, BUSY, 0);
        apply(1, 32'h500, 0, 0, 0, 0, BUSY, 0);
        chk("t1_ren_pre", {31'b0, bus.ramREN}, 32'd1);
        #1;
        nrst = 0;
        #1;
        model_reset();
        check_all();
        chk("t1_ren",   {31'b0, bus.ramREN}, 32'd0);
        chk("t1_iwait", {31'b0, bus.iwait}, 32'd1);
        idle_inputs();
        @(negedge clk);
        nrst = 1;
        step(1, 32'h600, 0, 0, 0, 0, BUSY, 0);
        apply(1, 32'h600, 0, 0, 0, 0, ACCESS, 32'hABCD);
        chk("t1_addr",  bus.ramaddr, 32'h600);
        chk("t1_iwait", {31'b0, bus.iwait}, 32'd0);
        tick();

        // random traffic with sticky requests, aborts and RAM states
        ir = 0; dr = 0; dw = 0;
        for (int k = 0; k < 1500; k++) begin
            ir = ir ? (($urandom % 16) != 0) : (($urandom % 3) == 0);
            dr = dr ? (($urandom % 16) != 0) : (($urandom % 4) == 0);
            dw = dw ? (($urandom % 16) != 0) : (($urandom % 6) == 0);
            step(ir, $urandom, dr, dw, $urandom, $urandom, 2'($urandom % 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
